// File: rtl/slice_draw_pkg.sv
// Shared screen geometry, colour constants, FSM encoding and the row-band colour rule
// for the slice column drawer.
package slice_draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int COL_W    = 8;
    localparam int ROW_W    = 7;
    localparam int COLOUR_W = 3;
    localparam int BOUND_W  = 8;

    localparam logic [COLOUR_W-1:0] CEIL_COLOUR   = 3'b001;
    localparam logic [COLOUR_W-1:0] FLOOR_COLOUR  = 3'b010;
    localparam logic [COLOUR_W-1:0] WALL_COLOUR_H = 3'b111;
    localparam logic [COLOUR_W-1:0] WALL_COLOUR_V = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Rows above top are ceiling, [top, bot) is wall, the rest is floor.
    function automatic logic [COLOUR_W-1:0] band_colour(
        input logic [ROW_W-1:0]    row,
        input logic [BOUND_W-1:0]  top,
        input logic [BOUND_W-1:0]  bot,
        input logic [COLOUR_W-1:0] ceil_c,
        input logic [COLOUR_W-1:0] wall_c,
        input logic [COLOUR_W-1:0] floor_c
    );
        logic [BOUND_W-1:0] r;
        r = {1'b0, row};
        if (r < top)      return ceil_c;
        else if (r < bot) return wall_c;
        else              return floor_c;
    endfunction

endpackage

// File: rtl/slice_column_drawer_if.sv
// Slice request and pixel-write bundle between the slice-height stage, the drawer
// and the VGA adapter.
interface slice_column_drawer_if;
    import slice_draw_pkg::*;

    logic                start;
    logic [COL_W-1:0]    column;
    logic [ROW_W-1:0]    slice_size;
    logic                wall_side;

    logic                busy;
    logic                done;
    logic [COL_W-1:0]    x;
    logic [ROW_W-1:0]    y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;

    modport master (
        output start, column, slice_size, wall_side,
        input  busy, done, x, y, colour, plot
    );

    modport slave (
        input  start, column, slice_size, wall_side,
        output busy, done, x, y, colour, plot
    );

endinterface

// File: rtl/slice_bounds.sv
// Combinational: clamps the projected height to the screen and centres it,
// giving the wall band [top, bot) in 8-bit unsigned rows.
module slice_bounds #(
    parameter int SCREEN_H = slice_draw_pkg::SCREEN_H
) (
    input  logic [slice_draw_pkg::ROW_W-1:0]   slice_size,
    input  logic [slice_draw_pkg::ROW_W-1:0]   h,
    output logic [slice_draw_pkg::ROW_W-1:0]   h_clamp,
    output logic [slice_draw_pkg::BOUND_W-1:0] top,
    output logic [slice_draw_pkg::BOUND_W-1:0] bot
);
    import slice_draw_pkg::*;

    assign h_clamp = (int'(slice_size) > SCREEN_H) ? ROW_W'(SCREEN_H) : slice_size;

    // h never exceeds SCREEN_H, so the difference is non-negative and bot <= SCREEN_H.
    assign top = BOUND_W'((SCREEN_H - int'(h)) >> 1);
    assign bot = top + BOUND_W'(h);

endmodule

// File: rtl/slice_column_drawer.sv
// Paints one full-height screen column (ceiling / wall / floor); DRAW_SHADE_EN picks wall colour by hit side.
// First plot 2 cycles after start, done at SCREEN_H+2; start is ignored while busy, nothing is queued.
module slice_column_drawer #(
    parameter int                                  SCREEN_W      = slice_draw_pkg::SCREEN_W,
    parameter int                                  SCREEN_H      = slice_draw_pkg::SCREEN_H,
    parameter logic [slice_draw_pkg::COLOUR_W-1:0] CEIL_COLOUR   = slice_draw_pkg::CEIL_COLOUR,
    parameter logic [slice_draw_pkg::COLOUR_W-1:0] FLOOR_COLOUR  = slice_draw_pkg::FLOOR_COLOUR,
    parameter logic [slice_draw_pkg::COLOUR_W-1:0] WALL_COLOUR_H = slice_draw_pkg::WALL_COLOUR_H,
    parameter logic [slice_draw_pkg::COLOUR_W-1:0] WALL_COLOUR_V = slice_draw_pkg::WALL_COLOUR_V
) (
    input  logic                 clock,
    input  logic                 resetn,
    slice_column_drawer_if.slave bus
);
    import slice_draw_pkg::*;

    state_t               state;
    logic [COL_W-1:0]     col_q;
    logic [ROW_W-1:0]     h_q;
    logic [BOUND_W-1:0]   top_q;
    logic [BOUND_W-1:0]   bot_q;
    logic [ROW_W-1:0]     row;

    logic [ROW_W-1:0]     h_clamp;
    logic [BOUND_W-1:0]   top_c;
    logic [BOUND_W-1:0]   bot_c;
    logic [COLOUR_W-1:0]  wall_c;
    logic [ROW_W-1:0]     row_nx;
    logic                 last_row;
    logic                 col_off_screen;

    slice_bounds #(
        .SCREEN_H (SCREEN_H)
    ) u_bounds (
        .slice_size (bus.slice_size),
        .h          (h_q),
        .h_clamp    (h_clamp),
        .top        (top_c),
        .bot        (bot_c)
    );

`ifdef DRAW_SHADE_EN
    logic side_q;
    assign wall_c = side_q ? WALL_COLOUR_V : WALL_COLOUR_H;
`else
    assign wall_c = WALL_COLOUR_H;
`endif

    assign row_nx         = row + 1'b1;
    assign last_row       = (int'(row) == SCREEN_H - 1);
    assign col_off_screen = (int'(col_q) >= SCREEN_W);

    // y/colour/plot are registered one row ahead, so the pixel on the bus always matches row.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.plot   <= 1'b0;
            bus.x      <= '0;
            bus.y      <= '0;
            bus.colour <= '0;
            col_q      <= '0;
            h_q        <= '0;
            top_q      <= '0;
            bot_q      <= '0;
            row        <= '0;
`ifdef DRAW_SHADE_EN
            side_q     <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        col_q    <= bus.column;
                        h_q      <= h_clamp;
`ifdef DRAW_SHADE_EN
                        side_q   <= bus.wall_side;
`endif
                        bus.busy <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    top_q <= top_c;
                    bot_q <= bot_c;
                    row   <= '0;
                    if (col_off_screen) begin
                        bus.done <= 1'b1;
                        state    <= FIN;
                    end else begin
                        bus.plot   <= 1'b1;
                        bus.x      <= col_q;
                        bus.y      <= '0;
                        bus.colour <= band_colour('0, top_c, bot_c, CEIL_COLOUR, wall_c, FLOOR_COLOUR);
                        state      <= DRAW;
                    end
                end
                DRAW: begin
                    if (last_row) begin
                        bus.plot <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= FIN;
                    end else begin
                        row        <= row_nx;
                        bus.y      <= row_nx;
                        bus.colour <= band_colour(row_nx, top_q, bot_q, CEIL_COLOUR, wall_c, FLOOR_COLOUR);
                    end
                end
                FIN: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.plot <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slice_column_drawer.sv
// Directed bench for slice_column_drawer: cycle-offset model of the pixel stream plus
// hand-computed per-slice band counts and latencies.
module tb_slice_column_drawer;

    localparam int W   = 160;
    localparam int H   = 120;
    localparam int TMO = 400;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    slice_column_drawer_if bus ();

    slice_column_drawer dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a slice accepted at an edge defines every output by its cycle offset rel.
    int ecount = 0;
    bit active = 1'b0;
    int s      = 0;
    int d_rel  = 0;
    int mcol   = 0;
    int msize  = 0;
    bit mside  = 1'b0;

    function automatic logic [2:0] exp_colour(input int yy);
        int hh, tp, bt;
        logic [2:0] wc;
        hh = (msize > H) ? H : msize;
        tp = (H - hh) / 2;
        bt = tp + hh;
`ifdef DRAW_SHADE_EN
        wc = mside ? 3'b110 : 3'b111;
`else
        wc = 3'b111;
`endif
        if (yy < tp) return 3'b001;
        if (yy < bt) return wc;
        return 3'b010;
    endfunction

    always @(posedge clock) begin
        int prev;
        if (!resetn) begin
            active = 1'b0;
        end else begin
            prev = ecount - s + 1;
            if (bus.start && (!active || prev > d_rel)) begin
                active = 1'b1;
                s      = ecount + 1;
                mcol   = int'(bus.column);
                msize  = int'(bus.slice_size);
                mside  = bus.wall_side;
                d_rel  = (mcol >= W) ? 2 : H + 2;
            end
        end
        ecount++;
    end

    // Observed tallies, read as deltas by the directed tests.
    int n_plot = 0, n_ceil = 0, n_wall = 0, n_floor = 0, n_v = 0, n_done = 0;
    int first_rel = -1, last_rel = -1, done_rel = -1;
    bit prev_plot = 1'b0;
    logic [7:0] last_x = '0;
    logic [6:0] last_y = '0;
    logic [2:0] last_c = '0;

    always @(negedge clock) begin
        int rel;
        bit eb, ed, ep;
        rel = ecount - s + 1;
        eb  = 1'b0;
        ed  = 1'b0;
        ep  = 1'b0;
        if (!resetn) begin
            last_x = '0;
            last_y = '0;
            last_c = '0;
        end else begin
            eb = active && rel >= 1 && rel <= d_rel;
            ed = active && rel == d_rel;
            ep = active && mcol < W && rel >= 2 && rel <= H + 1;
            if (ep) begin
                last_x = 8'(mcol);
                last_y = 7'(rel - 2);
                last_c = exp_colour(rel - 2);
            end
        end
        chk("cyc_busy",   32'(bus.busy),   32'(eb));
        chk("cyc_done",   32'(bus.done),   32'(ed));
        chk("cyc_plot",   32'(bus.plot),   32'(ep));
        chk("cyc_x",      32'(bus.x),      32'(last_x));
        chk("cyc_y",      32'(bus.y),      32'(last_y));
        chk("cyc_colour", 32'(bus.colour), 32'(last_c));
        if (resetn && bus.plot === 1'b1) begin
            n_plot++;
            if (!prev_plot) first_rel = rel;
            last_rel = rel;
            if (bus.colour === 3'b001) n_ceil++;
            if (bus.colour === 3'b111 || bus.colour === 3'b110) n_wall++;
            if (bus.colour === 3'b110) n_v++;
            if (bus.colour === 3'b010) n_floor++;
        end
        if (resetn && bus.done === 1'b1) begin
            n_done++;
            done_rel = rel;
        end
        prev_plot = (bus.plot === 1'b1);
    end

    int b_plot, b_ceil, b_wall, b_floor, b_v, b_done;

    task automatic snap();
        b_plot  = n_plot;
        b_ceil  = n_ceil;
        b_wall  = n_wall;
        b_floor = n_floor;
        b_v     = n_v;
        b_done  = n_done;
    endtask

    task automatic start_slice(input int col, input int sz, input bit side);
        @(posedge clock); #1;
        bus.start      = 1'b1;
        bus.column     = 8'(col);
        bus.slice_size = 7'(sz);
        bus.wall_side  = side;
        @(posedge clock); #1;
        bus.start      = 1'b0;
        bus.column     = 8'd77;
        bus.slice_size = 7'd5;
        bus.wall_side  = ~side;
    endtask

    task automatic wait_done(input string name);
        int i;
        i = 0;
        while (n_done == b_done && i < TMO) begin
            @(posedge clock);
            i++;
        end
        chk({name, "_timeout"}, 32'(n_done > b_done), 32'd1);
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic expect_slice(input string name, input int p, input int c, input int w,
                                input int f, input int drel);
        chk({name, "_plots"},   32'(n_plot - b_plot),   32'(p));
        chk({name, "_ceil"},    32'(n_ceil - b_ceil),   32'(c));
        chk({name, "_wall"},    32'(n_wall - b_wall),   32'(w));
        chk({name, "_floor"},   32'(n_floor - b_floor), 32'(f));
        chk({name, "_dones"},   32'(n_done - b_done),   32'd1);
        chk({name, "_donecyc"}, 32'(done_rel),          32'(drel));
    endtask

    task automatic wait_rel(input int target);
        int i;
        i = 0;
        while ((ecount - s + 1) < target && i < TMO) begin
            @(posedge clock); #1;
            i++;
        end
        chk("wait_rel_reached", 32'(ecount - s + 1), 32'(target));
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.column     = '0;
        bus.slice_size = '0;
        bus.wall_side  = 1'b0;
        resetn         = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_done",   32'(bus.done),   32'd0);
        chk("rst_plot",   32'(bus.plot),   32'd0);
        chk("rst_x",      32'(bus.x),      32'd0);
        chk("rst_y",      32'(bus.y),      32'd0);
        chk("rst_colour", 32'(bus.colour), 32'd0);
        resetn = 1'b1;

        // Nominal 40-row slice: 40 ceiling, 40 wall, 40 floor.
        snap();
        start_slice(10, 40, 1'b0);
        wait_done("s40");
        expect_slice("s40", 120, 40, 40, 40, 122);
        chk("s40_first_plot", 32'(first_rel), 32'd2);
        chk("s40_last_plot",  32'(last_rel),  32'd121);
        chk("s40_hold_x",      32'(bus.x),      32'd10);
        chk("s40_hold_y",      32'(bus.y),      32'd119);
        chk("s40_hold_colour", 32'(bus.colour), 32'd2);
        chk("s40_idle_busy",   32'(bus.busy),   32'd0);

        // Odd height: top=56, bot=63.
        snap();
        start_slice(20, 7, 1'b0);
        wait_done("s7");
        expect_slice("s7", 120, 56, 7, 57, 122);

        // Zero height: split evenly, no wall.
        snap();
        start_slice(30, 0, 1'b0);
        wait_done("s0");
        expect_slice("s0", 120, 60, 0, 60, 122);

        // Oversize: clamped to a full-height wall.
        snap();
        start_slice(40, 127, 1'b0);
        wait_done("s127");
        expect_slice("s127", 120, 0, 120, 0, 122);

        // Off-screen column: no pixels, done two cycles after start.
        snap();
        start_slice(160, 40, 1'b0);
        wait_done("c160");
        expect_slice("c160", 0, 0, 0, 0, 2);
        chk("c160_hold_x", 32'(bus.x), 32'd40);

        // Hit side: shaded wall only when the shading build is selected.
        snap();
        start_slice(50, 40, 1'b1);
        wait_done("side1");
        expect_slice("side1", 120, 40, 40, 40, 122);
`ifdef DRAW_SHADE_EN
        chk("side1_v_rows", 32'(n_v - b_v), 32'd40);
`else
        chk("side1_v_rows", 32'(n_v - b_v), 32'd0);
`endif
        snap();
        start_slice(60, 40, 1'b0);
        wait_done("side0");
        chk("side0_v_rows", 32'(n_v - b_v), 32'd0);

        // A start arriving mid-draw is dropped, not queued.
        snap();
        start_slice(70, 40, 1'b0);
        wait_rel(50);
        bus.start      = 1'b1;
        bus.column     = 8'd99;
        bus.slice_size = 7'd0;
        bus.wall_side  = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        wait_done("busy_start");
        expect_slice("busy_start", 120, 40, 40, 40, 122);
        repeat (10) @(posedge clock);
        #1;
        chk("busy_start_single_done", 32'(n_done - b_done), 32'd1);
        chk("busy_start_idle",        32'(bus.busy),        32'd0);

        // Reset in the middle of a draw.
        snap();
        start_slice(80, 40, 1'b0);
        wait_rel(30);
        #1;
        resetn = 1'b0;
        #1;
        chk("midrst_plot", 32'(bus.plot), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("midrst_no_done", 32'(n_done - b_done), 32'd0);

        snap();
        start_slice(90, 40, 1'b0);
        wait_done("after_rst");
        expect_slice("after_rst", 120, 40, 40, 40, 122);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slice_column_drawer.md
SLICE_COLUMN_DRAWER -- requirements
Module: slice_column_drawer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, screen width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 120, screen height in pixels.
REQ-003 SHALL have parameter CEIL_COLOUR, default 3'b001, ceiling colour.
REQ-004 SHALL have parameter FLOOR_COLOUR, default 3'b010, floor colour.
REQ-005 SHALL have parameter WALL_COLOUR_H, default 3'b111, wall colour for a horizontal-grid hit.
REQ-006 SHALL have parameter WALL_COLOUR_V, default 3'b110, wall colour for a vertical-grid hit.
REQ-007 SHALL have port clock, input, 1 bit; single clock, all logic on its rising edge.
REQ-008 SHALL have port resetn, input, 1 bit; reset is asynchronous and active-low.
REQ-009 SHALL have port start, input, 1 bit; slice valid, sampled only in IDLE.
REQ-010 SHALL have port column, input, 8 bits; screen x of the slice.
REQ-011 SHALL have port slice_size, input, 7 bits; projected wall height from the slice-height stage.
REQ-012 SHALL have port wall_side, input, 1 bit; 0 = horizontal-grid hit, 1 = vertical-grid hit.
REQ-013 SHALL have port busy, output, 1 bit; high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit; one-cycle completion pulse.
REQ-015 SHALL have ports x (8 bits), y (7 bits), colour (3 bits) and plot (1 bit), all outputs, forming the pixel write to the VGA adapter.

Function
REQ-016 SHALL implement the states IDLE, LOAD, DRAW and FIN.
REQ-017 SHALL, in IDLE with start=1, latch column, wall_side and h = min(slice_size, SCREEN_H), then enter LOAD.
REQ-018 SHALL, in LOAD, register top = (SCREEN_H - h) >> 1 and bot = top + h (bot exclusive), clear the row counter, and enter DRAW, or enter FIN directly when column >= SCREEN_W.
REQ-019 SHALL, in DRAW, assert plot each cycle with x = latched column, y = row, and colour = CEIL_COLOUR if row < top, wall colour if row < bot, FLOOR_COLOUR otherwise; row increments by 1 per cycle.
REQ-020 SHALL leave DRAW for FIN after row = SCREEN_H-1; FIN asserts done for exactly one cycle and returns to IDLE.
REQ-021 SHALL meet this latency: start sampled at cycle 0, LOAD at cycle 1, first plot at cycle 2, last plot at cycle SCREEN_H+1, done at cycle SCREEN_H+2.
REQ-022 SHALL ignore start while busy=1; a slice is not queued.
REQ-023 SHALL, when h = 0, make top = bot = SCREEN_H/2, so the column contains no wall pixels.
REQ-024 SHALL, when slice_size > SCREEN_H, clamp so that all SCREEN_H rows are wall.
REQ-025 SHALL hold plot=0 in every state other than DRAW; x, y and colour hold their last values.
REQ-026 SHALL compute all arithmetic unsigned, with top and bot 8 bits wide so the sum cannot overflow.

Reset
REQ-027 SHALL, while resetn=0, force IDLE, busy=0, done=0, plot=0, x=0, y=0, colour=0, and clear the latched registers.
REQ-028 SHALL, on reset during DRAW, deassert plot immediately with no done pulse; after reset release the block accepts a new start.

Configuration
REQ-029 SHALL, with DRAW_SHADE_EN defined, use WALL_COLOUR_V as the wall colour when the latched wall_side = 1 and WALL_COLOUR_H otherwise.
REQ-030 SHALL, without DRAW_SHADE_EN, always use WALL_COLOUR_H and ignore wall_side (its latch register omitted).

Structure
REQ-031 SHALL place SCREEN_W, SCREEN_H, the colour constants and the state encoding in shared package slice_draw_pkg.
REQ-032 SHALL place the combinational clamp and top/bot computation in sub-module slice_bounds.

Verification
REQ-033 SHALL test: start, column=10, slice_size=40, wall_side=0 -> plots at cycles 2..121, y=0..39 CEIL, y=40..79 3'b111, y=80..119 FLOOR, done at cycle 122.
REQ-034 SHALL test: slice_size=7 -> top=56, bot=63, rows 56..62 wall; slice_size=0 -> no wall pixels, 60 CEIL rows and 60 FLOOR rows.
REQ-035 SHALL test: slice_size=127 -> all 120 rows wall; column=160 -> zero plots and done at cycle 2.
REQ-036 SHALL test: second start at cycle 50 of a draw -> ignored, only 120 plots, one done.
REQ-037 SHALL test: resetn low at cycle 30 -> plot, busy and done all 0 immediately; new start after release -> full 120-row draw.
REQ-038 SHALL test: with DRAW_SHADE_EN, wall_side=1 -> wall colour 3'b110; without DRAW_SHADE_EN -> 3'b111.
